// File: rtl/io_bus_bridge.sv
// io_bus_bridge
//
// Pad-side bus slave between the pad-ring I/O cells and the core register file.
// It terminates the address / write-data / read-data valid-ready handshakes coming
// from the pads and turns each accepted transaction into a single-cycle register
// strobe towards the core. It also provides:
//   - an address range check: addresses >= NUM_REGS are never strobed
//   - a write-data timeout: a write is abandoned after TIMEOUT cycles without WVALID
//   - a sticky error flag, ERR
//
// Only one transaction is in flight at a time. Every output comes straight from a
// flop.
//
// Parameters
//   ADDR_W    address width
//   DATA_W    data width
//   NUM_REGS  number of implemented registers
//   RD_LAT    cycles from REG_REN to valid REG_RDATA (1..4)
//   TIMEOUT   cycles to wait for WVALID before the write is abandoned (1..255)
//   ERR_DATA  RDATA value returned for out-of-range reads
//
// Ports
//   ACLK, ARESETB      clock; asynchronous active-low reset
//   AADDR, AWRITEB     request address; 0 = write, 1 = read
//   AVALID, AREADY     address handshake (AREADY is high whenever the bridge is idle)
//   WDATA, WVALID      write data from the host
//   WREADY             write data accepted
//   RDATA, RVALID      read response to the host
//   RREADY             host ready for read data
//   REG_ADDR           core register address
//   REG_WEN            one-cycle write strobe
//   REG_WDATA          core write data
//   REG_REN            one-cycle read strobe
//   REG_RDATA          core read data, valid RD_LAT cycles after REG_REN
//   ERR, ERR_CLR       sticky error flag and its clear input

module io_bus_bridge #(
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       NUM_REGS = 48,
  parameter int unsigned       RD_LAT   = 1,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(8'hEE)
) (
  input  logic              ACLK,
  input  logic              ARESETB,
  input  logic [ADDR_W-1:0] AADDR,
  input  logic              AWRITEB,
  input  logic              AVALID,
  output logic              AREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic              REG_WEN,
  output logic [DATA_W-1:0] REG_WDATA,
  output logic              REG_REN,
  input  logic [DATA_W-1:0] REG_RDATA,
  output logic              ERR,
  input  logic              ERR_CLR
);

  // Transaction states
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWaitW = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StRwait = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  // One extra bit so that NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NumRegsLim  = (ADDR_W + 1)'(NUM_REGS);
  // A single 8-bit counter serves as both the write timeout and the read latency counter.
  localparam logic [7:0]      TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [7:0]      RdLatLast   = 8'(RD_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              in_range_q, in_range_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              aready_q, wready_q, rvalid_q, wen_q, ren_q;
  logic              addr_in_range;

  assign addr_in_range = ({1'b0, AADDR} < NumRegsLim);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_range_d = in_range_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // aready_q gates acceptance so that the first cycle after reset release is never taken.
        if (AVALID && aready_q) begin
          addr_d     = AADDR;
          in_range_d = addr_in_range;
          cnt_d      = 8'd0;
          if (!AWRITEB) begin
            state_d = StWaitW;
          end else if (addr_in_range) begin
            state_d = StRead;
          end else begin
            state_d = StResp;
            rdata_d = ERR_DATA;
            err_set = 1'b1;
          end
        end
      end

      StWaitW: begin
        // If data arrives on the timeout cycle, the data wins.
        if (WVALID) begin
          wdata_d = WDATA;
          if (in_range_q) begin
            state_d = StWrite;
          end else begin
            state_d = StIdle;
            err_set = 1'b1;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StWrite: begin
        state_d = StIdle;
      end

      StRead: begin
        state_d = StRwait;
        cnt_d   = 8'd0;
      end

      StRwait: begin
        if (cnt_q == RdLatLast) begin
          rdata_d = REG_RDATA;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StResp: begin
        if (RREADY) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // If a new error and a clear happen in the same cycle, the error is kept.
    err_d = err_set | (err_q & ~ERR_CLR);
  end

  always_ff @(posedge ACLK or negedge ARESETB) begin
    if (!ARESETB) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      in_range_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      aready_q   <= 1'b0;
      wready_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_range_q <= in_range_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      // Handshake and strobe outputs are decoded from the next state, which keeps them
      // registered and exactly aligned with the state they belong to.
      aready_q   <= (state_d == StIdle);
      wready_q   <= (state_d == StWaitW);
      rvalid_q   <= (state_d == StResp);
      wen_q      <= (state_d == StWrite);
      ren_q      <= (state_d == StRead);
    end
  end

  assign AREADY    = aready_q;
  assign WREADY    = wready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign REG_ADDR  = addr_q;
  assign REG_WEN   = wen_q;
  assign REG_WDATA = wdata_q;
  assign REG_REN   = ren_q;
  assign ERR       = err_q;

endmodule
